// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module  : uart_pkg
// Brief   : Shared UART types: TX queue FSM states and stop-bit encodings.
// Rev     : 1.0  initial release
// ============================================================================
package uart_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_WAIT  = 2'd2
  } txq_state_t;

  // Stop-bit selection codes understood by the serializer.
  localparam logic [1:0] c_STOPBITS_1   = 2'd0;
  localparam logic [1:0] c_STOPBITS_1P5 = 2'd1;
  localparam logic [1:0] c_STOPBITS_2   = 2'd2;

  localparam int unsigned c_BYTE_W = 8;

endpackage
`default_nettype wire

// File: rtl/uart_fifo.sv
`default_nettype none
// ============================================================================
// Module  : uart_fifo
// Brief   : Synchronous FIFO with registered level/full/empty flags.
// Rev     : 1.0  initial release
// ============================================================================
module uart_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_wr_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int c_PW = $clog2(DEPTH);
  localparam int c_LW = c_PW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [c_PW-1:0]  r_wr_ptr;
  logic [c_PW-1:0]  r_rd_ptr;
  logic [c_LW-1:0]  r_level;
  logic [c_LW-1:0]  w_level_nxt;
  logic             r_full;
  logic             r_empty;
  logic             w_pop;
  logic             w_push;

  // A push into a full FIFO is legal only when the head leaves on the same edge.
  assign w_pop  = i_pop && !r_empty;
  assign w_push = i_push && (!r_full || w_pop);

  always_comb begin
    w_level_nxt = r_level;
    if (w_push && !w_pop) begin
      w_level_nxt = r_level + c_LW'(1);
    end else if (!w_push && w_pop) begin
      w_level_nxt = r_level - c_LW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  // Flags come from the next level so all three stay consistent every cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + c_PW'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + c_PW'(1);
      end
      r_level <= w_level_nxt;
      r_full  <= (w_level_nxt == c_LW'(DEPTH));
      r_empty <= (w_level_nxt == '0);
    end
  end

  assign o_rd_data = r_mem[r_rd_ptr];
  assign o_level   = r_level;
  assign o_full    = r_full;
  assign o_empty   = r_empty;

endmodule
`default_nettype wire

// File: rtl/uart_tx_queue.sv
`default_nettype none
// ============================================================================
// Module  : uart_tx_queue
// Brief   : Byte FIFO feeding a UART serializer through an IDLE/START/WAIT FSM.
//           Define UART_TXQ_OVERFLOW_CNT_EN to add overflow/drop_count outputs.
// Rev     : 1.0  initial release
// ============================================================================
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  logic [7:0]             wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic [7:0]             tx_data,
  output logic                   tx_start,
  input  logic                   tx_done,
  output logic                   busy
`ifdef UART_TXQ_OVERFLOW_CNT_EN
  ,
  output logic                   overflow,
  output logic [7:0]             drop_count
`endif
);

  txq_state_t                 r_state;
  txq_state_t                 w_state_nxt;
  logic                       w_pop;
  logic                       w_push;
  logic                       w_load;
  logic [7:0]                 w_head;
  logic [7:0]                 r_tx_data;
  logic [$clog2(DEPTH):0]     w_level;
  logic                       w_full;
  logic                       w_empty;

  assign w_pop  = (r_state == ST_START);
  assign w_push = wr_en && (!w_full || w_pop);

  uart_fifo #(
    .WIDTH (8),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .i_push    (w_push),
    .i_wr_data (wr_data),
    .i_pop     (w_pop),
    .o_rd_data (w_head),
    .o_level   (w_level),
    .o_full    (w_full),
    .o_empty   (w_empty)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_empty) begin
          w_state_nxt = ST_START;
          w_load      = 1'b1;
        end
      end
      ST_START: w_state_nxt = ST_WAIT;
      ST_WAIT: begin
        if (tx_done) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // The head byte is captured on entry to START so it is valid in START
  // and held unchanged through WAIT while the FIFO moves on.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_tx_data <= 8'h00;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_tx_data <= w_head;
      end
    end
  end

  assign tx_start = (r_state == ST_START);
  assign tx_data  = r_tx_data;
  assign busy     = (r_state != ST_IDLE);
  assign full     = w_full;
  assign empty    = w_empty;
  assign level    = w_level;

`ifdef UART_TXQ_OVERFLOW_CNT_EN
  logic       w_drop;
  logic       r_overflow;
  logic [7:0] r_drop_count;

  assign w_drop = wr_en && w_full && !w_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow   <= 1'b0;
      r_drop_count <= 8'h00;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
      if (r_drop_count != 8'hFF) begin
        r_drop_count <= r_drop_count + 8'd1;
      end
    end
  end

  assign overflow   = r_overflow;
  assign drop_count = r_drop_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_queue.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module  : tb_uart_tx_queue
// Brief   : Directed + randomized self-checking bench for uart_tx_queue.
// Rev     : 1.0  initial release
// ============================================================================
module tb_uart_tx_queue;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  always #5 clk = ~clk;

  // DEPTH=16 instance for the directed steps
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       tx_done = 1'b0;
  logic       full, empty, busy, tx_start;
  logic [4:0] level;
  logic [7:0] tx_data;
`ifdef UART_TXQ_OVERFLOW_CNT_EN
  logic       overflow, s_overflow;
  logic [7:0] drop_count, s_drop_count;
`endif

  // DEPTH=4 instance for the randomized stream
  logic       s_wr_en = 1'b0;
  logic [7:0] s_wr_data = 8'h00;
  logic       s_tx_done = 1'b0;
  logic       s_full, s_empty, s_busy, s_tx_start;
  logic [2:0] s_level;
  logic [7:0] s_tx_data;

  int         n_err = 0;
  int         n_chk = 0;
  int         rcvd = 0;
  logic [7:0] sb[$];

  uart_tx_queue #(.DEPTH(16)) u_dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_data(wr_data),
    .full(full), .empty(empty), .level(level), .tx_data(tx_data),
    .tx_start(tx_start), .tx_done(tx_done), .busy(busy)
`ifdef UART_TXQ_OVERFLOW_CNT_EN
    , .overflow(overflow), .drop_count(drop_count)
`endif
  );

  uart_tx_queue #(.DEPTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .wr_en(s_wr_en), .wr_data(s_wr_data),
    .full(s_full), .empty(s_empty), .level(s_level), .tx_data(s_tx_data),
    .tx_start(s_tx_start), .tx_done(s_tx_done), .busy(s_busy)
`ifdef UART_TXQ_OVERFLOW_CNT_EN
    , .overflow(s_overflow), .drop_count(s_drop_count)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_done();
    tx_done = 1'b1;
    tick();
    tx_done = 1'b0;
  endtask

  task automatic wait_start(output int n);
    n = 0;
    while (tx_start !== 1'b1 && n < 200) begin
      tick();
      n++;
    end
    chk("start_seen", tx_start, 1);
  endtask

  // Serializer model for the stream instance: random busy time per byte,
  // checks byte order against the scoreboard and the restart latency.
  initial begin : serializer
    logic exp_start;
    exp_start = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      if (exp_start) chk("stream_latency", s_tx_start, 1);
      exp_start = 1'b0;
      if (s_tx_start === 1'b1) begin
        chk("stream_sb_nonempty", (sb.size() != 0), 1);
        if (sb.size() != 0) begin
          chk("stream_order", s_tx_data, sb.pop_front());
          rcvd++;
        end
        repeat ($urandom_range(1, 12)) @(posedge clk);
        #3;
        s_tx_done = 1'b1;
        @(posedge clk);
        #3;
        s_tx_done = 1'b0;
        exp_start = (sb.size() != 0);
      end
    end
  end

  initial begin
    int n, sent, guard;

    // Reset values; a write during reset must not land
    rst = 1'b1; wr_en = 1'b1; wr_data = 8'hEE;
    tick(); tick();
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_tx_start", tx_start, 0);
    chk("rst_tx_data", tx_data, 8'h00);
    chk("rst_busy", busy, 0);
`ifdef UART_TXQ_OVERFLOW_CNT_EN
    chk("rst_overflow", overflow, 0);
    chk("rst_drop_count", drop_count, 0);
`endif
    wr_en = 1'b0; rst = 1'b0;
    tick();
    chk("wr_in_rst_empty", empty, 1);
    chk("wr_in_rst_busy", busy, 0);

    // Single byte latency
    wr_en = 1'b1; wr_data = 8'hA5;
    tick();
    wr_en = 1'b0;
    chk("lat_edgeN_start", tx_start, 0);
    chk("lat_edgeN_level", level, 1);
    tick();
    chk("lat_start", tx_start, 1);
    chk("lat_data", tx_data, 8'hA5);
    chk("lat_busy", busy, 1);
    tick();
    chk("pop_empty", empty, 1);
    chk("wait_busy", busy, 1);
    chk("wait_no_start", tx_start, 0);
    chk("wait_data", tx_data, 8'hA5);
    pulse_done();
    chk("done_idle", busy, 0);

    // Three back-to-back bytes, serializer answers ~100 cycles after each start
    for (int i = 0; i < 3; i++) begin
      wr_en = 1'b1; wr_data = 8'(i + 1);
      tick();
      if (i == 1) begin
        chk("b2b_first_start", tx_start, 1);
        chk("b2b_first_data", tx_data, 8'h01);
      end
    end
    wr_en = 1'b0;
    chk("b2b_level", level, 2);
    for (int i = 1; i < 3; i++) begin
      repeat (98) tick();
      chk("b2b_hold", tx_data, 8'(i));
      pulse_done();
      wait_start(n);
      chk("b2b_latency", n, 1);
      chk("b2b_data", tx_data, 8'(i + 1));
    end
    repeat (98) tick();
    pulse_done();
    chk("b2b_end_busy", busy, 0);
    chk("b2b_end_empty", empty, 1);

    // Stalled serializer: one byte in flight, then 17 writes
    wr_en = 1'b1; wr_data = 8'h10;
    tick();
    wr_en = 1'b0;
    tick(); tick();
    chk("stall_busy", busy, 1);
    chk("stall_empty", empty, 1);
    for (int i = 0; i < 17; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h20 + i);
      tick();
    end
    wr_en = 1'b0;
    chk("fill_full", full, 1);
    chk("fill_level", level, 16);
    chk("fill_empty", empty, 0);
`ifdef UART_TXQ_OVERFLOW_CNT_EN
    chk("fill_overflow", overflow, 1);
    chk("fill_drop_count", drop_count, 1);
`endif

    // Write into a full queue on the START pop edge; tx_done in START ignored
    pulse_done();
    tick();
    chk("refill_start", tx_start, 1);
    chk("refill_head", tx_data, 8'h20);
    wr_en = 1'b1; wr_data = 8'h55; tx_done = 1'b1;
    tick();
    wr_en = 1'b0; tx_done = 1'b0;
    chk("popwr_level", level, 16);
    chk("popwr_full", full, 1);
    chk("done_in_start_ignored", busy, 1);
`ifdef UART_TXQ_OVERFLOW_CNT_EN
    chk("popwr_no_drop", drop_count, 1);
    for (int i = 0; i < 260; i++) begin
      wr_en = 1'b1; wr_data = 8'hCC;
      tick();
    end
    wr_en = 1'b0;
    chk("drop_saturate", drop_count, 8'hFF);
    chk("drop_sticky", overflow, 1);
    chk("drop_level", level, 16);
`endif

    // Reset in WAIT with five bytes queued
    rst = 1'b1; tick(); rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      wr_en = 1'b1; wr_data = 8'(8'h60 + i);
      tick();
    end
    wr_en = 1'b0;
    tick();
    chk("pre_rst_level", level, 5);
    chk("pre_rst_busy", busy, 1);
    rst = 1'b1; tick(); rst = 1'b0;
    chk("midrst_empty", empty, 1);
    chk("midrst_level", level, 0);
    chk("midrst_busy", busy, 0);
    chk("midrst_tx_start", tx_start, 0);
    chk("midrst_full", full, 0);
`ifdef UART_TXQ_OVERFLOW_CNT_EN
    chk("midrst_drop_count", drop_count, 0);
`endif
    pulse_done();
    chk("stray_done_busy", busy, 0);
    chk("stray_done_start", tx_start, 0);
    tick();
    chk("stray_done_idle", tx_start, 0);

    // Randomized 300-byte stream through DEPTH=4, producer honours full
    sent = 0; guard = 0;
    while (sent < 300 && guard < 20000) begin
      s_wr_en = 1'b0;
      if ($urandom_range(0, 3) != 0 && s_full === 1'b0) begin
        s_wr_en = 1'b1;
        s_wr_data = 8'($urandom);
      end
      tick();
      guard++;
      if (s_wr_en) begin
        sb.push_back(s_wr_data);
        sent++;
      end
      chk("stream_empty_vs_level", s_empty, (s_level == 3'd0));
      chk("stream_full_vs_level", s_full, (s_level == 3'd4));
    end
    s_wr_en = 1'b0;
    chk("stream_sent", sent, 300);
    guard = 0;
    while (rcvd < 300 && guard < 8000) begin
      tick();
      guard++;
    end
    chk("stream_rcvd", rcvd, 300);
    chk("stream_sb_drained", sb.size(), 0);
    repeat (20) tick();
    chk("stream_final_empty", s_empty, 1);
    chk("stream_final_level", s_level, 0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
